// File: rtl/serial_word_fifo.sv
// serial_word_fifo
//   Assembles DATA_W-bit words from a strobed serial bit stream. Completed
//   words go into a DEPTH-entry circular queue, and the queue is drained one
//   word per dequeue request.
//
// Ports
//   clock        : single rising-edge clock
//   reset        : synchronous, active-low
//   data_in      : serial bit, sampled on an accepted write strobe
//   write_in     : bit strobe (level), acted on at its rising edge
//   status_out   : 1 = serial bits are accepted (queue not full), registered
//   dequeue_in   : pop request (level), acted on at its rising edge
//   data_out     : word removed by the most recent successful pop
//   len_out      : number of queued words
//   full_out     : len_out == DEPTH
//   empty_out    : len_out == 0
//   overflow_out : sticky, a strobe arrived while status_out was 0
module serial_word_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_in,
  input  logic              write_in,
  output logic              status_out,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);

  logic              write_q, deq_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              status_q, status_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_pulse, deq_pulse, accept, last_bit, push, pop;

  always_comb begin
    wr_pulse  = write_in & ~write_q;
    deq_pulse = dequeue_in & ~deq_q;

    // Bits are gated before entering the shift register, so a full queue
    // parks a partial word instead of losing it.
    accept   = wr_pulse & status_q;
    last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    push     = accept & last_bit;
    pop      = deq_pulse & (len_q != '0);

    if (MSB_FIRST != 0) shifted = {shreg_q[DATA_W-2:0], data_in};
    else                shifted = {data_in, shreg_q[DATA_W-1:1]};

    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    dout_d   = dout_q;

    if (accept) begin
      shreg_d = shifted;
      cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   len_d = len_q + LEN_W'(1);
      2'b01:   len_d = len_q - LEN_W'(1);
      default: len_d = len_q;
    endcase

    status_d = (len_d < LEN_W'(DEPTH));
    ovf_d    = ovf_q | (wr_pulse & ~status_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      write_q  <= 1'b0;
      deq_q    <= 1'b0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      status_q <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      write_q  <= write_in;
      deq_q    <= dequeue_in;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  // Queue storage needs no reset: entries are only read after being written.
  // The completed word includes the bit arriving on this same edge.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= shreg_d;
  end

  assign status_out   = status_q;
  assign data_out     = dout_q;
  assign len_out      = len_q;
  assign full_out     = (len_q == LEN_W'(DEPTH));
  assign empty_out    = (len_q == '0);
  assign overflow_out = ovf_q;

endmodule
